// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM.
// Sequences fetch/decode/execute/memory/writeback for addu, subu, ori, lw,
// sw, beq and j, and drives the shared datapath and unified memory port.
module mc_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_sel,
  output logic       mem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_op,
  output logic [1:0] alu_op,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       instr_done,
  output logic       illegal
);

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, WB_R, EXEC_ORI, WB_I, MEM_ADDR,
    MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, TRAP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  state_t state;

  // State register; TRAP is left only through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:    if (mem_ready) state <= DECODE;
        DECODE: begin
          case (op)
            OP_RTYPE: state <= (funct == FN_ADDU || funct == FN_SUBU) ? EXEC_R : TRAP;
            OP_ORI:   state <= EXEC_ORI;
            OP_LW,
            OP_SW:    state <= MEM_ADDR;
            OP_BEQ:   state <= BRANCH;
            OP_J:     state <= JUMP;
            default:  state <= TRAP;
          endcase
        end
        EXEC_R:   state <= WB_R;
        WB_R:     state <= FETCH;
        EXEC_ORI: state <= WB_I;
        WB_I:     state <= FETCH;
        MEM_ADDR: state <= (op == OP_LW) ? MEM_RD : MEM_WR;
        MEM_RD:   if (mem_ready) state <= MEM_WB;
        MEM_WB:   state <= FETCH;
        MEM_WR:   if (mem_ready) state <= FETCH;
        BRANCH:   state <= FETCH;
        JUMP:     state <= FETCH;
        TRAP:     state <= TRAP;
        default:  state <= FETCH;
      endcase
    end
  end

  // Output decode of state; everything is held low while reset is asserted
  // so an aborted instruction cannot issue a partial write.
  always_comb begin
    mem_req    = 1'b0;
    mem_sel    = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    ext_op     = 1'b0;
    alu_op     = 2'b00;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    if (rst_n) begin
      case (state)
        FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          ir_we     = mem_ready;
          pc_we     = mem_ready;
        end
        DECODE: begin
          alu_src_b = 2'b11;
          ext_op    = 1'b1;
        end
        EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = (funct == FN_SUBU) ? 2'b01 : 2'b00;
        end
        WB_R: begin
          reg_we     = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        EXEC_ORI: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = 2'b10;
        end
        WB_I: begin
          reg_we     = 1'b1;
          instr_done = 1'b1;
        end
        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          ext_op    = 1'b1;
        end
        MEM_RD: begin
          mem_req = 1'b1;
          mem_sel = 1'b1;
        end
        MEM_WB: begin
          reg_we     = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        MEM_WR: begin
          mem_req    = 1'b1;
          mem_sel    = 1'b1;
          mem_we     = 1'b1;
          instr_done = mem_ready;
        end
        BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = 2'b01;
          pc_src     = 2'b01;
          pc_we      = zero;
          instr_done = 1'b1;
        end
        JUMP: begin
          pc_src     = 2'b10;
          pc_we      = 1'b1;
          instr_done = 1'b1;
        end
        TRAP:    illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: scoreboard bench for mc_ctrl. Stimulus drives each cycle and
// queues the expected control word; a monitor pops and compares mid-cycle.
module tb_mc_ctrl;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_sel, mem_we, ir_we, pc_we;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       ext_op;
  logic [1:0] alu_op;
  logic       reg_we, reg_dst, mem_to_reg, instr_done, illegal;

  mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_sel(mem_sel),
    .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_op(ext_op),
    .alu_op(alu_op), .reg_we(reg_we), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .instr_done(instr_done), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [17:0] word;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nerr = 0;

  // Field order: req sel we ir_we pc_we pc_src a_src b_src ext alu_op
  //              reg_we reg_dst m2r done illegal
  function automatic logic [17:0] cw(
    input logic rq, input logic sl, input logic mw, input logic iw,
    input logic pw, input logic [1:0] ps, input logic sa,
    input logic [1:0] sb, input logic ex, input logic [1:0] ao,
    input logic rw, input logic rd, input logic mr, input logic dn,
    input logic il);
    return {rq, sl, mw, iw, pw, ps, sa, sb, ex, ao, rw, rd, mr, dn, il};
  endfunction

  wire [17:0] act = {mem_req, mem_sel, mem_we, ir_we, pc_we, pc_src,
                     alu_src_a, alu_src_b, ext_op, alu_op, reg_we,
                     reg_dst, mem_to_reg, instr_done, illegal};

  // Hand-derived control words per state.
  logic [17:0] W_IDLE, W_FETCH, W_FWAIT, W_DEC, W_ADDU, W_SUBU, W_WBR,
               W_ORI, W_WBI, W_MADDR, W_MRD, W_MWB, W_MWR, W_MWRW,
               W_BEQ1, W_BEQ0, W_JMP, W_TRAP;
  initial begin
    W_IDLE  = '0;
    W_FETCH = cw(1,0,0,1,1,2'b00,0,2'b01,0,2'b00,0,0,0,0,0);
    W_FWAIT = cw(1,0,0,0,0,2'b00,0,2'b01,0,2'b00,0,0,0,0,0);
    W_DEC   = cw(0,0,0,0,0,2'b00,0,2'b11,1,2'b00,0,0,0,0,0);
    W_ADDU  = cw(0,0,0,0,0,2'b00,1,2'b00,0,2'b00,0,0,0,0,0);
    W_SUBU  = cw(0,0,0,0,0,2'b00,1,2'b00,0,2'b01,0,0,0,0,0);
    W_WBR   = cw(0,0,0,0,0,2'b00,0,2'b00,0,2'b00,1,1,0,1,0);
    W_ORI   = cw(0,0,0,0,0,2'b00,1,2'b10,0,2'b10,0,0,0,0,0);
    W_WBI   = cw(0,0,0,0,0,2'b00,0,2'b00,0,2'b00,1,0,0,1,0);
    W_MADDR = cw(0,0,0,0,0,2'b00,1,2'b10,1,2'b00,0,0,0,0,0);
    W_MRD   = cw(1,1,0,0,0,2'b00,0,2'b00,0,2'b00,0,0,0,0,0);
    W_MWB   = cw(0,0,0,0,0,2'b00,0,2'b00,0,2'b00,1,0,1,1,0);
    W_MWR   = cw(1,1,1,0,0,2'b00,0,2'b00,0,2'b00,0,0,0,1,0);
    W_MWRW  = cw(1,1,1,0,0,2'b00,0,2'b00,0,2'b00,0,0,0,0,0);
    W_BEQ1  = cw(0,0,0,0,1,2'b01,1,2'b00,0,2'b01,0,0,0,1,0);
    W_BEQ0  = cw(0,0,0,0,0,2'b01,1,2'b00,0,2'b01,0,0,0,1,0);
    W_JMP   = cw(0,0,0,0,1,2'b10,0,2'b00,0,2'b00,0,0,0,1,0);
    W_TRAP  = cw(0,0,0,0,0,2'b00,0,2'b00,0,2'b00,0,0,0,0,1);
  end

  // Monitor: one expected word per cycle, sampled away from the rising edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      nvec++;
      if (act !== e.word) begin
        nerr++;
        $display("FAIL %s: got %b expected %b (t=%0t)", e.name, act, e.word, $time);
      end
    end
  end

  task automatic cyc(input string nm, input logic [17:0] w,
                     input logic rdy, input logic z);
    exp_t e;
    mem_ready = rdy;
    zero      = z;
    e.name = nm;
    e.word = w;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic [5:0] o, input logic [5:0] f);
    op    = o;
    funct = f;
  endtask

  initial begin
    rst_n = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    #1;
    cyc("reset_outputs", W_IDLE, 1, 0);
    cyc("reset_outputs", W_IDLE, 1, 1);
    rst_n = 1'b1;

    // addu: 4 cycles
    set_ir(6'h00, 6'h21);
    cyc("addu_fetch", W_FETCH, 1, 0);
    cyc("addu_decode", W_DEC, 1, 0);
    cyc("addu_exec", W_ADDU, 1, 0);
    cyc("addu_wb", W_WBR, 1, 0);
    // subu: 4 cycles, one fetch wait state first
    set_ir(6'h00, 6'h23);
    cyc("subu_fetch_wait", W_FWAIT, 0, 0);
    cyc("subu_fetch", W_FETCH, 1, 0);
    cyc("subu_decode", W_DEC, 1, 0);
    cyc("subu_exec", W_SUBU, 1, 0);
    cyc("subu_wb", W_WBR, 1, 0);
    // ori
    set_ir(6'h0D, 6'h3F);
    cyc("ori_fetch", W_FETCH, 1, 0);
    cyc("ori_decode", W_DEC, 1, 0);
    cyc("ori_exec", W_ORI, 1, 0);
    cyc("ori_wb", W_WBI, 1, 0);
    // lw with two wait cycles in MEM_RD: 7 cycles
    set_ir(6'h23, 6'h00);
    cyc("lw_fetch", W_FETCH, 1, 0);
    cyc("lw_decode", W_DEC, 1, 0);
    cyc("lw_addr", W_MADDR, 1, 0);
    cyc("lw_rd_wait", W_MRD, 0, 0);
    cyc("lw_rd_wait", W_MRD, 0, 0);
    cyc("lw_rd", W_MRD, 1, 0);
    cyc("lw_wb", W_MWB, 1, 0);
    // sw: 4 cycles
    set_ir(6'h2B, 6'h00);
    cyc("sw_fetch", W_FETCH, 1, 0);
    cyc("sw_decode", W_DEC, 1, 0);
    cyc("sw_addr", W_MADDR, 1, 0);
    cyc("sw_wr", W_MWR, 1, 0);
    // beq taken / not taken: 3 cycles each
    set_ir(6'h04, 6'h00);
    cyc("beq_t_fetch", W_FETCH, 1, 0);
    cyc("beq_t_decode", W_DEC, 1, 0);
    cyc("beq_taken", W_BEQ1, 1, 1);
    cyc("beq_n_fetch", W_FETCH, 1, 1);
    cyc("beq_n_decode", W_DEC, 1, 1);
    cyc("beq_not_taken", W_BEQ0, 1, 0);
    // j: 3 cycles
    set_ir(6'h02, 6'h00);
    cyc("j_fetch", W_FETCH, 1, 0);
    cyc("j_decode", W_DEC, 1, 0);
    cyc("j_jump", W_JMP, 1, 0);

    // illegal opcode: sticky TRAP, mem_ready toggling ignored
    set_ir(6'h3F, 6'h00);
    cyc("ill_fetch", W_FETCH, 1, 0);
    cyc("ill_decode", W_DEC, 1, 0);
    for (int i = 0; i < 20; i++) cyc("trap_hold", W_TRAP, i[0], i[1]);
    rst_n = 1'b0;
    cyc("trap_reset", W_IDLE, 1, 0);
    rst_n = 1'b1;
    // unsupported funct under op 0 also traps
    set_ir(6'h00, 6'h20);
    cyc("badfn_fetch", W_FETCH, 1, 0);
    cyc("badfn_decode", W_DEC, 1, 0);
    cyc("badfn_trap", W_TRAP, 1, 0);
    cyc("badfn_trap", W_TRAP, 1, 0);
    rst_n = 1'b0;
    cyc("badfn_reset", W_IDLE, 1, 0);
    rst_n = 1'b1;

    // reset during a waiting store aborts it; no write after release
    set_ir(6'h2B, 6'h00);
    cyc("swab_fetch", W_FETCH, 1, 0);
    cyc("swab_decode", W_DEC, 1, 0);
    cyc("swab_addr", W_MADDR, 1, 0);
    cyc("swab_wr_wait", W_MWRW, 0, 0);
    begin
      exp_t e;
      mem_ready = 1'b0;
      #1 rst_n = 1'b0;
      e.name = "swab_mid_reset";
      e.word = W_IDLE;
      q.push_back(e);
      @(posedge clk);
      #1;
    end
    cyc("swab_reset_hold", W_IDLE, 1, 0);
    rst_n = 1'b1;
    set_ir(6'h00, 6'h21);
    cyc("post_fetch_wait", W_FWAIT, 0, 0);
    cyc("post_fetch", W_FETCH, 1, 0);
    cyc("post_decode", W_DEC, 1, 0);
    cyc("post_exec", W_ADDU, 1, 0);
    cyc("post_wb", W_WBR, 1, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      nerr++;
      $display("FAIL drain: %0d expected words left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
